// File: rtl/star_bar_renderer.sv
// star_bar_renderer: pixel-side reader for the star-bar sprite ROM.
// Maps the scan position onto one of four 96x16 star images, pipelines the
// ROM colour out as an overlay pixel, and blinks the bar after a level rise.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   SHOW  | bar shows the latched level steadily
//   BLINK | bar alternates between the 0-star image and the latched
//         | level every BLINK_HALF frames, for BLINK_FRAMES frames
module star_bar_renderer #(
  parameter int unsigned BAR_X        = 528,
  parameter int unsigned BAR_Y        = 16,
  parameter int unsigned BAR_W        = 96,
  parameter int unsigned BAR_H        = 16,
  parameter int unsigned BLINK_FRAMES = 48,
  parameter int unsigned BLINK_HALF   = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_start,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [1:0]  star_level_in,
  output logic [12:0] rom_addr,
  input  logic [23:0] rom_data,
  output logic        bar_on,
  output logic [23:0] bar_rgb,
  output logic [1:0]  disp_level
);

  typedef enum logic {SHOW = 1'b0, BLINK = 1'b1} state_t;

  // Box edges are widened by one bit so the right/bottom limits never wrap.
  localparam logic [10:0] X_LO     = 11'(BAR_X);
  localparam logic [10:0] X_HI     = 11'(BAR_X + BAR_W);
  localparam logic [10:0] Y_LO     = 11'(BAR_Y);
  localparam logic [10:0] Y_HI     = 11'(BAR_Y + BAR_H);
  localparam logic [12:0] IMG_SIZE = 13'(BAR_W * BAR_H);
  localparam logic [12:0] ROW_LEN  = 13'(BAR_W);
  localparam logic [7:0]  BLINK_N  = 8'(BLINK_FRAMES);
  localparam logic [3:0]  HALF_END = 4'(BLINK_HALF - 1);

  state_t      state_q, state_d;
  logic [1:0]  level_d;
  logic [7:0]  blink_cnt, blink_d;
  logic [3:0]  phase_cnt, phase_cnt_d;
  logic        phase, phase_d;

  logic [1:0]  art_level;
  logic        in_box;
  logic [10:0] dx, dy;
  logic [12:0] pix_addr;
  logic        v1, v2;

  // Frame-rate state register: level latch, blink counters and FSM state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= SHOW;
      disp_level <= 2'd0;
      blink_cnt  <= 8'd0;
      phase_cnt  <= 4'd0;
      phase      <= 1'b0;
    end else begin
      state_q    <= state_d;
      disp_level <= level_d;
      blink_cnt  <= blink_d;
      phase_cnt  <= phase_cnt_d;
      phase      <= phase_d;
    end
  end

  // Next-state logic; only a frame_start edge can change anything.
  always_comb begin
    state_d     = state_q;
    level_d     = disp_level;
    blink_d     = blink_cnt;
    phase_cnt_d = phase_cnt;
    phase_d     = phase;
    if (frame_start) begin
      if (star_level_in > disp_level) begin
        // A rise (re)starts a full blink, opening on the 0-star half.
        level_d     = star_level_in;
        state_d     = BLINK;
        blink_d     = BLINK_N;
        phase_cnt_d = 4'd0;
        phase_d     = 1'b0;
      end else if (star_level_in < disp_level) begin
        level_d     = star_level_in;
        state_d     = SHOW;
        blink_d     = 8'd0;
        phase_cnt_d = 4'd0;
        phase_d     = 1'b0;
      end else if (state_q == BLINK) begin
        blink_d = blink_cnt - 8'd1;
        if (phase_cnt == HALF_END) begin
          phase_cnt_d = 4'd0;
          phase_d     = ~phase;
        end else begin
          phase_cnt_d = phase_cnt + 4'd1;
        end
        if (blink_cnt == 8'd1) begin
          state_d     = SHOW;
          blink_d     = 8'd0;
          phase_cnt_d = 4'd0;
          phase_d     = 1'b0;
        end
      end
    end
  end

  // Image actually drawn: the off half of a blink uses the 0-star art.
  always_comb begin
    art_level = disp_level;
    if (state_q == BLINK && !phase) art_level = 2'd0;
  end

  // Box test and ROM address for the current scan position.
  always_comb begin
    in_box   = ({1'b0, DrawX} >= X_LO) && ({1'b0, DrawX} < X_HI) &&
               ({1'b0, DrawY} >= Y_LO) && ({1'b0, DrawY} < Y_HI);
    dx       = {1'b0, DrawX} - X_LO;
    dy       = {1'b0, DrawY} - Y_LO;
    pix_addr = 13'(art_level) * IMG_SIZE + {2'b00, dy} * ROW_LEN + {2'b00, dx};
  end

  // Three-stage pixel pipeline: address, ROM read, colour out.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rom_addr <= 13'd0;
      v1       <= 1'b0;
      v2       <= 1'b0;
      bar_on   <= 1'b0;
      bar_rgb  <= 24'h000000;
    end else begin
      rom_addr <= in_box ? pix_addr : 13'd0;
      v1       <= in_box;
      v2       <= v1;
      bar_on   <= v2;
      bar_rgb  <= v2 ? rom_data : 24'h000000;
    end
  end

endmodule

// File: tb/tb_star_bar_renderer.sv
// Self-checking bench for star_bar_renderer with a frame-level reference model.
module tb_star_bar_renderer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_start;
  logic [9:0]  DrawX, DrawY;
  logic [1:0]  star_level_in;
  logic [12:0] rom_addr;
  logic [23:0] rom_data;
  logic        bar_on;
  logic [23:0] bar_rgb;
  logic [1:0]  disp_level;

  int total = 0;
  int bad   = 0;

  // Reference model: latched level, blink frames left, frames since the rise.
  int   m_lvl, m_left, m_age;
  logic e_v[3];
  int   e_addr[3];

  star_bar_renderer dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
    .DrawX(DrawX), .DrawY(DrawY), .star_level_in(star_level_in),
    .rom_addr(rom_addr), .rom_data(rom_data), .bar_on(bar_on),
    .bar_rgb(bar_rgb), .disp_level(disp_level)
  );

  always #5 Clk = ~Clk;

  function automatic logic [23:0] rom_fn(input logic [12:0] a);
    return {a[10:0] ^ 11'h2A5, a};
  endfunction

  // Synchronous ROM stand-in.
  always @(posedge Clk) rom_data <= rom_fn(rom_addr);

  function automatic logic inbox(input int x, input int y);
    return (x >= 528) && (x < 624) && (y >= 16) && (y < 32);
  endfunction

  function automatic int art_model();
    if (m_left > 0 && ((m_age / 4) % 2) == 0) return 0;
    return m_lvl;
  endfunction

  function automatic logic [23:0] exp_rgb();
    return e_v[2] ? rom_fn(13'(e_addr[2])) : 24'h000000;
  endfunction

  task automatic model_reset();
    m_lvl = 0; m_left = 0; m_age = 0;
    for (int i = 0; i < 3; i++) begin e_v[i] = 1'b0; e_addr[i] = 0; end
  endtask

  task automatic model_frame(input int lvl);
    if (lvl > m_lvl) begin
      m_lvl = lvl; m_left = 48; m_age = 0;
    end else if (lvl < m_lvl) begin
      m_lvl = lvl; m_left = 0;
    end else if (m_left > 0) begin
      m_left--; m_age++;
    end
  endtask

  // One clock: drive at negedge, update the model at the posedge, return at next negedge.
  task automatic cycle(input logic fs, input int x, input int y, input int lvl);
    logic ib;
    frame_start   = fs;
    DrawX         = 10'(x);
    DrawY         = 10'(y);
    star_level_in = 2'(lvl);
    @(posedge Clk);
    ib = inbox(x, y);
    e_v[2] = e_v[1]; e_v[1] = e_v[0]; e_v[0] = ib;
    e_addr[2] = e_addr[1]; e_addr[1] = e_addr[0];
    e_addr[0] = ib ? art_model() * 1536 + (y - 16) * 96 + (x - 528) : 0;
    if (fs) model_frame(lvl);
    @(negedge Clk);
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if (rom_addr !== 13'd0 || bar_on !== 1'b0 || bar_rgb !== 24'h0 || disp_level !== 2'd0) begin
      bad++;
      $display("FAIL reset_state: addr=%0d on=%b rgb=%h lvl=%0d required all 0", rom_addr, bar_on, bar_rgb, disp_level);
    end
    cycle(1'b1, 0, 0, 2);
    for (int i = 0; i < 4; i++) cycle(1'b0, 600, 20, 0);
    total++;
    if (bar_on !== e_v[2] || bar_rgb !== exp_rgb()) begin
      bad++;
      $display("FAIL pre_reset_pixel: on=%b rgb=%h required on=%b rgb=%h", bar_on, bar_rgb, e_v[2], exp_rgb());
    end
    #2 Reset = 1'b1;
    #1;
    total++;
    if (rom_addr !== 13'd0 || bar_on !== 1'b0 || bar_rgb !== 24'h0 || disp_level !== 2'd0) begin
      bad++;
      $display("FAIL async_reset: addr=%0d on=%b rgb=%h lvl=%0d required all 0", rom_addr, bar_on, bar_rgb, disp_level);
    end
    model_reset();
    @(negedge Clk);
    Reset = 1'b0;
    for (int f = 1; f <= 6; f++) begin
      cycle(1'b1, 0, 0, 2);
      cycle(1'b0, 528, 16, 0);
      total++;
      if (rom_addr !== 13'(e_addr[0]) || disp_level !== 2'(m_lvl)) begin
        bad++;
        $display("FAIL after_reset_blink f%0d: addr=%0d lvl=%0d required addr=%0d lvl=%0d", f, rom_addr, disp_level, e_addr[0], m_lvl);
      end
    end
  endtask

  task automatic test_addr_map();
    int xs[$];
    int ys[$];
    xs = '{528, 623, 624, 527, 600, 528, 623};
    ys = '{16,  31,  31,  16,  20,  15,  32};
    cycle(1'b1, 0, 0, 0);
    for (int i = 0; i < 60; i++) begin
      xs.push_back($urandom_range(500, 650));
      ys.push_back($urandom_range(5, 40));
    end
    for (int i = 0; i < xs.size() + 2; i++) begin
      if (i < xs.size()) cycle(1'b0, xs[i], ys[i], $urandom_range(0, 3));
      else cycle(1'b0, 0, 0, 0);
      total++;
      if (rom_addr !== 13'(e_addr[0])) begin
        bad++;
        $display("FAIL addr_map i%0d: rom_addr=%0d required=%0d", i, rom_addr, e_addr[0]);
      end
      total++;
      if (bar_on !== e_v[2] || bar_rgb !== exp_rgb()) begin
        bad++;
        $display("FAIL pixel_out i%0d: on=%b rgb=%h required on=%b rgb=%h", i, bar_on, bar_rgb, e_v[2], exp_rgb());
      end
    end
  endtask

  task automatic blink_frames(input string name, input int lvl, input int img);
    int want;
    for (int f = 1; f <= 52; f++) begin
      cycle(1'b0, 528, 16, $urandom_range(0, 3));
      want = (f <= 48 && ((f - 1) / 4) % 2 == 0) ? 0 : img;
      total++;
      if (rom_addr !== 13'(e_addr[0]) || rom_addr !== 13'(want)) begin
        bad++;
        $display("FAIL %s frame%0d: rom_addr=%0d required=%0d (model %0d)", name, f, rom_addr, want, e_addr[0]);
      end
      cycle(1'b0, 0, 0, 0);
      cycle(1'b0, 0, 0, 0);
      total++;
      if (bar_on !== 1'b1 || bar_rgb !== rom_fn(13'(want))) begin
        bad++;
        $display("FAIL %s_rgb frame%0d: on=%b rgb=%h required on=1 rgb=%h", name, f, bar_on, bar_rgb, rom_fn(13'(want)));
      end
      cycle(1'b1, 0, 0, lvl);
    end
  endtask

  task automatic test_blink();
    cycle(1'b1, 0, 0, 2);
    total++;
    if (disp_level !== 2'd2) begin
      bad++;
      $display("FAIL blink_latch: disp_level=%0d required=2", disp_level);
    end
    blink_frames("blink", 2, 3072);
  endtask

  task automatic test_decrease();
    cycle(1'b1, 0, 0, 3);
    for (int f = 0; f < 6; f++) cycle(1'b1, 0, 0, 3);
    cycle(1'b1, 0, 0, 1);
    cycle(1'b0, 528, 16, 0);
    total++;
    if (disp_level !== 2'd1 || rom_addr !== 13'd1536 || rom_addr !== 13'(e_addr[0])) begin
      bad++;
      $display("FAIL decrease: lvl=%0d addr=%0d required lvl=1 addr=1536", disp_level, rom_addr);
    end
    cycle(1'b1, 0, 0, 1);
    cycle(1'b0, 528, 16, 0);
    total++;
    if (rom_addr !== 13'd1536) begin
      bad++;
      $display("FAIL decrease_steady: addr=%0d required=1536", rom_addr);
    end
  endtask

  task automatic test_rise_in_blink();
    cycle(1'b1, 0, 0, 0);
    cycle(1'b1, 0, 0, 1);
    for (int f = 0; f < 38; f++) cycle(1'b1, 0, 0, 1);
    cycle(1'b1, 0, 0, 3);
    total++;
    if (disp_level !== 2'd3) begin
      bad++;
      $display("FAIL rise_latch: disp_level=%0d required=3", disp_level);
    end
    blink_frames("rise_blink", 3, 4608);
  endtask

  task automatic test_boundaries();
    int xs[6] = '{623, 528, 528, 1023, 600, 623};
    int ys[6] = '{31,  15,  32,  1023, 1023, 31};
    for (int i = 0; i < 8; i++) begin
      if (i < 6) cycle(1'b0, xs[i], ys[i], 0);
      else cycle(1'b0, 0, 0, 0);
      total++;
      if (rom_addr !== 13'(e_addr[0]) || bar_on !== e_v[2] || bar_rgb !== exp_rgb()) begin
        bad++;
        $display("FAIL boundary i%0d: addr=%0d on=%b rgb=%h required addr=%0d on=%b rgb=%h",
                 i, rom_addr, bar_on, bar_rgb, e_addr[0], e_v[2], exp_rgb());
      end
      if (i == 0) begin
        total++;
        if (rom_addr !== 13'd6143) begin
          bad++;
          $display("FAIL max_addr: rom_addr=%0d required=6143", rom_addr);
        end
      end
    end
    for (int i = 0; i < 5; i++) cycle(1'b0, 0, 0, i % 3);
    total++;
    if (disp_level !== 2'd3) begin
      bad++;
      $display("FAIL no_frame_start: disp_level=%0d required=3", disp_level);
    end
  endtask

  task automatic test_random();
    int lvl, x, y;
    for (int f = 0; f < 60; f++) begin
      lvl = ($urandom_range(0, 9) < 7) ? m_lvl : $urandom_range(0, 3);
      cycle(1'b1, 0, 0, lvl);
      total++;
      if (disp_level !== 2'(m_lvl)) begin
        bad++;
        $display("FAIL rand_level f%0d: disp_level=%0d required=%0d", f, disp_level, m_lvl);
      end
      for (int p = 0; p < 15; p++) begin
        x = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 1023) : $urandom_range(510, 640);
        y = $urandom_range(0, 40);
        cycle(1'b0, x, y, $urandom_range(0, 3));
        total++;
        if (rom_addr !== 13'(e_addr[0]) || bar_on !== e_v[2] || bar_rgb !== exp_rgb()) begin
          bad++;
          $display("FAIL rand_pixel f%0d p%0d: addr=%0d on=%b rgb=%h required addr=%0d on=%b rgb=%h",
                   f, p, rom_addr, bar_on, bar_rgb, e_addr[0], e_v[2], exp_rgb());
        end
      end
    end
  endtask

  initial begin
    Reset = 1'b1; frame_start = 1'b0; DrawX = '0; DrawY = '0; star_level_in = '0;
    model_reset();
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    test_reset();
    test_addr_map();
    test_blink();
    test_decrease();
    test_rise_in_blink();
    test_boundaries();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
